id_exe_stage: RTL
=================

# id_exe_stage

Decode-to-execute pipeline stage of the tartaruga core. It registers the decoded operation (PC, both source operands, ALU operation, destination register and write enable) and presents it to the ALU. It decouples the two stages with a valid/ready handshake and a one-entry skid buffer, so no combinational path runs from `ready_i` to `ready_o`. A flush input discards in-flight operations on branch redirect.

## Interface
- No parameters. Widths are fixed by `tartaruga_pkg`.

- `clk_i` in 1: core clock, all state on rising edge.
- `rstn_i` in 1: asynchronous reset, active-low.
- `flush_i` in 1: synchronous flush, highest priority.
- `valid_i` in 1: upstream has a decoded op.
- `ready_o` out 1: stage can accept an op this cycle.
- `pc_i` in `bus32_t`: PC of the op.
- `data_rs1_i`, `data_rs2_i` in `bus32_t`: source operand values.
- `alu_op_i` in `alu_op_t`: ALU operation.
- `rd_addr_i` in `reg_addr_t` (5): destination register.
- `rd_we_i` in 1: op writes `rd`.
- `valid_o` out 1: op presented to execute.
- `ready_i` in 1: execute accepts the op.
- `pc_o`, `data_rs1_o`, `data_rs2_o` out `bus32_t`: registered payload, feeding the ALU `data_rs1_i`/`data_rs2_i`.
- `alu_op_o` out `alu_op_t`: registered op, feeding the ALU `alu_op_i`.
- `rd_addr_o` out 5: registered destination.
- `rd_we_o` out 1: `main.rd_we & valid_o`.

## Operation
- Two payload slots: `main` drives outputs; `skid` catches one op when the stage stalls.
- Input transfer: `valid_i & ready_o`. Output transfer: `valid_o & ready_i`.
- Control state machine (`id_exe_state_t`):
  - EMPTY: `valid_o=0`, `ready_o=1`. On input transfer, `main<=in` and go to ONE.
  - ONE: `valid_o=1`, `ready_o=1`.
    - Input and output transfer: `main<=in`, stay in ONE.
    - Input only: `skid<=in`, go to FULL.
    - Output only: go to EMPTY.
    - Neither: hold.
  - FULL: `valid_o=1`, `ready_o=0`. On output transfer, `main<=skid` and go to ONE. Otherwise hold.
- `ready_o` and `valid_o` are decoded from the registered state only.
- While `valid_o & ~ready_i`, every output holds stable. There is no reordering, no loss and no duplication.
- Flush: `flush_i=1` at a clock edge puts the state in EMPTY regardless of other inputs. An op presented in the flush cycle is dropped, even if `ready_o=1`. Payload registers need not clear.
- Reset (asynchronous, any state): state EMPTY; `valid_o=0`; `ready_o=1`; `rd_we_o=0`. All payload registers, and hence `pc_o`, `data_rs1_o`, `data_rs2_o`, `alu_op_o` and `rd_addr_o`, clear to `'0`.
- `rd_addr_o = 0` with `rd_we_o = 1` passes through unchanged; x0 suppression belongs to writeback.

## Timing
- Latency: 1 cycle from input transfer to `valid_o`, when the stage was EMPTY or draining.
- Throughput: 1 op/cycle when `ready_i` is held high.
- `ready_o` falls the cycle after the first stalled accept, i.e. the cycle the state enters FULL. At most one extra op is absorbed.
- After `ready_i` rises in FULL, `ready_o` returns the next cycle.
- `flush_i` takes effect at the next edge. `valid_o=0` and `ready_o=1` in the following cycle.

## Structure
- Add to `tartaruga_pkg`:
  - `reg_addr_t` (`logic [4:0]`).
  - Struct `id_exe_t` holding `pc`, `rs1`, `rs2`, `alu_op`, `rd_addr` and `rd_we`.
  - Enum `id_exe_state_t` with values EMPTY, ONE, FULL.
- `main` and `skid` are both `id_exe_t` registers.
- Single module, no sub-modules. Execute instantiates `alu` on its outputs.

## Test plan
- Reset:
  - Stimulus: `rstn_i=0` with `valid_i=1`.
  - Required: `valid_o=0`, `ready_o=1`, `rd_we_o=0`, all payload outputs `0`.
  - Then: release with no input; outputs stay unchanged.
- Streaming:
  - Stimulus: `ready_i=1`, four back-to-back ops, PC `0x0`, `0x4`, `0x8`, `0xC`, `ADD`, rs1/rs2 = `1,2`/`3,4`/…
  - Required: each appears on `valid_o` one cycle after accept, with no bubbles and `ready_o` constantly 1.
- Backpressure:
  - Stimulus: accept PC `0x10`, drop `ready_i`, present PC `0x14` and `0x18`.
  - Required:
    - `0x14` goes to skid; `ready_o=0` next cycle; `0x18` is held upstream.
    - Outputs stay at `0x10` while stalled.
    - After `ready_i=1`, outputs show `0x10`, `0x14`, `0x18` in order.
- Flush while FULL:
  - Stimulus: `flush_i=1` with `valid_i=1`, PC `0x20`.
  - Required: next cycle `valid_o=0`, `ready_o=1`; `0x20` is never output.
- Reset mid-operation:
  - Stimulus: assert `rstn_i` low asynchronously in FULL, between clock edges.
  - Required: `valid_o` drops immediately; after release the stage is EMPTY.
- Write-enable gating:
  - Stimulus: op with `rd_we_i=1`, `rd_addr_i=5`, then an idle cycle.
  - Required: `rd_we_o=1` only while `valid_o=1`; 0 in the idle cycle.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core.
// Bus, register-address, ALU-op and ID/EXE bundle definitions.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        bus32_t    pc;
        bus32_t    rs1;
        bus32_t    rs2;
        alu_op_t   alu_op;
        reg_addr_t rd_addr;
        logic      rd_we;
    } id_exe_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } id_exe_state_t;

endpackage

// File: rtl/id_exe_stage.sv
// Decode-to-execute register stage with a one-entry skid buffer.
// Handshake flags come from registered state only.
module id_exe_stage
    import tartaruga_pkg::*;
(
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      flush_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  bus32_t    pc_i,
    input  bus32_t    data_rs1_i,
    input  bus32_t    data_rs2_i,
    input  alu_op_t   alu_op_i,
    input  reg_addr_t rd_addr_i,
    input  logic      rd_we_i,
    output logic      valid_o,
    input  logic      ready_i,
    output bus32_t    pc_o,
    output bus32_t    data_rs1_o,
    output bus32_t    data_rs2_o,
    output alu_op_t   alu_op_o,
    output reg_addr_t rd_addr_o,
    output logic      rd_we_o
);

    id_exe_state_t state, state_next;
    id_exe_t       main, skid, op_in;
    logic          in_xfer, out_xfer;
    logic          ld_main_in, ld_main_skid, ld_skid;

    assign op_in = '{
        pc:      pc_i,
        rs1:     data_rs1_i,
        rs2:     data_rs2_i,
        alu_op:  alu_op_i,
        rd_addr: rd_addr_i,
        rd_we:   rd_we_i
    };

    assign ready_o  = (state != FULL);
    assign valid_o  = (state != EMPTY);
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        state_next   = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush_i) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        ld_main_in = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        ld_main_in = 1'b1;
                    end else if (in_xfer) begin
                        ld_skid    = 1'b1;
                        state_next = FULL;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        ld_main_skid = 1'b1;
                        state_next   = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= EMPTY;
            main  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            if (ld_main_in) begin
                main <= op_in;
            end else if (ld_main_skid) begin
                main <= skid;
            end
            if (ld_skid) begin
                skid <= op_in;
            end
        end
    end

    // x0 writes pass through; writeback owns suppression.
    assign pc_o       = main.pc;
    assign data_rs1_o = main.rs1;
    assign data_rs2_o = main.rs2;
    assign alu_op_o   = main.alu_op;
    assign rd_addr_o  = main.rd_addr;
    assign rd_we_o    = main.rd_we & valid_o;

endmodule
